// File: rtl/pipe_ctl.sv
// pipe_ctl -- pipeline sequencing controller for the 4-stage-register 16-bit core.
//
// Converts the PAUSE switch level and the debounced STEP press into per-stage
// advance enables (run / halt / single-step), and optionally stalls the front
// of the pipe for one advance cycle on a load-use hazard.
//
// Optional feature macro: HAZARD_INTERLOCK_EN
//   defined   -> load-use detection active, stall_cnt counts bubble cycles
//   undefined -> hazard forced to 0, stall_cnt tied to 0, hazard inputs ignored
//
// Ports:
//   CLK, RST       clock; asynchronous active-high reset
//   pause          level, 1 = halt requested
//   step_pulse     one-cycle pulse from the debouncer
//   idex_memread   ID/EX holds a load
//   idex_wa        ID/EX load destination register
//   ifid_ra/rb     IF/ID source registers; ifid_uses_rb qualifies rb
//   pc_en          PC and IF/ID update enable
//   idex_en        ID/EX update enable
//   idex_bubble    ID/EX loads NOP control instead of decode
//   exmem_en       EX/MEM update enable
//   memwb_en       MEM/WB update enable
//   state          00 HALT, 01 RUN, 10 STEP
//   cycle_cnt      advance cycles since reset (wraps)
//   stall_cnt      bubble cycles since reset (saturates)
module pipe_ctl #(
  parameter int CNT_W   = 16,
  parameter int STALL_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               pause,
  input  logic               step_pulse,
  input  logic               idex_memread,
  input  logic [3:0]         idex_wa,
  input  logic [3:0]         ifid_ra,
  input  logic [3:0]         ifid_rb,
  input  logic               ifid_uses_rb,
  output logic               pc_en,
  output logic               idex_en,
  output logic               idex_bubble,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             adv;
  logic             hazard;

  // Enables decode only the state register, so pause/step_pulse never reach
  // the pipeline registers combinationally.
  assign adv = (state_q == ST_RUN) | (state_q == ST_STEP);

  // A step_pulse arriving while already in STEP is simply not looked at,
  // which is what drops it instead of queueing a second step.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d; a missing
    // branch would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (!pause)          state_d = ST_RUN;
        else if (step_pulse) state_d = ST_STEP;
      end
      ST_RUN:  if (pause) state_d = ST_HALT;
      ST_STEP: state_d = pause ? ST_HALT : ST_RUN;
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (adv) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_HALT;
      cycle_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments in sequential blocks so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

`ifdef HAZARD_INTERLOCK_EN
  // r0 is deliberately not special-cased: a load to r0 still interlocks.
  assign hazard = idex_memread &
                  ((idex_wa == ifid_ra) | (ifid_uses_rb & (idex_wa == ifid_rb)));

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (adv && hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign hazard    = 1'b0;
  assign stall_cnt = '0;

  // Hazard inputs stay on the port list for drop-in compatibility.
  logic unused_hazard_in;
  assign unused_hazard_in = ^{idex_memread, idex_wa, ifid_ra, ifid_rb, ifid_uses_rb};
`endif

  // On a hazard the load moves on (EX/MEM, MEM/WB advance) while ID/EX takes a
  // NOP and PC/IF-ID hold, so the dependent instruction re-decodes next advance.
  assign pc_en       = adv & ~hazard;
  assign idex_en     = adv;
  assign idex_bubble = adv & hazard;
  assign exmem_en    = adv;
  assign memwb_en    = adv;
  assign state       = state_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_pipe_ctl.sv
// tb_pipe_ctl -- self-checking bench for pipe_ctl.
// Reference model: run mode as an integer plus integer counters updated from
// the sampled inputs at each rising edge.
module tb_pipe_ctl;

`ifdef HAZARD_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif

  localparam int CNT_W   = 16;
  localparam int STALL_W = 8;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               pause = 1'b1;
  logic               step_pulse = 1'b0;
  logic               idex_memread = 1'b0;
  logic [3:0]         idex_wa = '0;
  logic [3:0]         ifid_ra = '0;
  logic [3:0]         ifid_rb = '0;
  logic               ifid_uses_rb = 1'b0;
  logic               pc_en, idex_en, idex_bubble, exmem_en, memwb_en;
  logic [1:0]         state;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [STALL_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int m_mode  = M_HALT;
  int m_cyc   = 0;
  int m_stall = 0;

  pipe_ctl #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
    .CLK(CLK), .RST(RST), .pause(pause), .step_pulse(step_pulse),
    .idex_memread(idex_memread), .idex_wa(idex_wa), .ifid_ra(ifid_ra),
    .ifid_rb(ifid_rb), .ifid_uses_rb(ifid_uses_rb),
    .pc_en(pc_en), .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .state(state),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic bit model_hazard();
    return INTERLOCK && idex_memread &&
           ((idex_wa == ifid_ra) || (ifid_uses_rb && (idex_wa == ifid_rb)));
  endfunction

  // Expected {pc_en, idex_en, idex_bubble, exmem_en, memwb_en, state[1:0]}
  function automatic logic [6:0] exp_vec();
    bit adv, hz;
    logic [1:0] code;
    adv  = (m_mode != M_HALT);
    hz   = adv && model_hazard();
    code = (m_mode == M_RUN) ? 2'b01 : (m_mode == M_STEP) ? 2'b10 : 2'b00;
    return {adv && !hz, adv, hz, adv, adv, code};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {pc_en, idex_en, idex_bubble, exmem_en, memwb_en, state};
  endfunction

  task automatic model_reset();
    m_mode = M_HALT; m_cyc = 0; m_stall = 0;
  endtask

  // One clock: model samples the same inputs the DUT samples at the edge.
  task automatic tick();
    bit adv;
    @(posedge CLK);
    adv = (m_mode != M_HALT);
    if (adv) m_cyc = (m_cyc + 1) % (1 << CNT_W);
    if (adv && model_hazard() && m_stall < STALL_MAX) m_stall++;
    case (m_mode)
      M_HALT:  m_mode = !pause ? M_RUN : (step_pulse ? M_STEP : M_HALT);
      M_RUN:   m_mode = pause ? M_HALT : M_RUN;
      default: m_mode = pause ? M_HALT : M_RUN;
    endcase
    @(negedge CLK);
  endtask

  task automatic clear_hazard_inputs();
    idex_memread = 1'b0; idex_wa = 4'd0; ifid_ra = 4'd1; ifid_rb = 4'd2; ifid_uses_rb = 1'b0;
  endtask

  task automatic do_reset_release();
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_hazard_inputs();
    pause = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({dut_vec(), cycle_cnt, stall_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got vec=%b cyc=%0d stall=%0d, required all 0", dut_vec(), cycle_cnt, stall_cnt);
    end
    RST = 1'b0;
    model_reset();
    n_cmp++;
    if (state !== 2'b00 || idex_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_cycle: got state=%b idex_en=%b, required 00/0", state, idex_en);
    end
    tick();
    n_cmp++;
    if (dut_vec() !== 7'b11011_01) begin
      n_bad++;
      $display("FAIL run_enables: got %b, required %b", dut_vec(), 7'b11011_01);
    end
    repeat (10) tick();
    n_cmp++;
    if (cycle_cnt !== 16'd10) begin
      n_bad++;
      $display("FAIL run_cycle_cnt: got %0d, required 10", cycle_cnt);
    end
  endtask

  task automatic test_single_step();
    int windows;
    logic prev_en;
    pause = 1'b1;
    n_cmp++;
    if (idex_en !== 1'b1) begin
      n_bad++;
      $display("FAIL pause_edge_adv: got idex_en=%b, required 1", idex_en);
    end
    tick();
    n_cmp++;
    if (idex_en !== 1'b0 || state !== 2'b00) begin
      n_bad++;
      $display("FAIL pause_halts: got idex_en=%b state=%b, required 0/00", idex_en, state);
    end
    windows = 0;
    prev_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step_pulse = 1'b1;
      tick();
      step_pulse = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (idex_en === 1'b1 && prev_en !== 1'b1) windows++;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++;
          $display("FAIL step_outputs: got %b, required %b", dut_vec(), exp_vec());
        end
        prev_en = idex_en;
        tick();
      end
    end
    n_cmp++;
    if (windows != 3) begin
      n_bad++;
      $display("FAIL step_windows: got %0d, required 3", windows);
    end
    n_cmp++;
    if (cycle_cnt !== CNT_W'(m_cyc) || m_cyc != 14) begin
      n_bad++;
      $display("FAIL step_cycle_cnt: got %0d, required %0d (14)", cycle_cnt, m_cyc);
    end
  endtask

  task automatic test_double_step();
    int adv_cycles;
    adv_cycles = 0;
    step_pulse = 1'b1;
    tick();
    if (idex_en === 1'b1) adv_cycles++;
    tick();
    step_pulse = 1'b0;
    n_cmp++;
    if (state !== 2'b00) begin
      n_bad++;
      $display("FAIL double_step_state: got %b, required 00", state);
    end
    for (int c = 0; c < 4; c++) begin
      if (idex_en === 1'b1) adv_cycles++;
      tick();
    end
    n_cmp++;
    if (adv_cycles != 1) begin
      n_bad++;
      $display("FAIL double_step_adv: got %0d adv cycles, required 1", adv_cycles);
    end
  endtask

  task automatic test_hazard();
    pause = 1'b0;
    tick();
    idex_memread = 1'b1; idex_wa = 4'd3; ifid_ra = 4'd3; ifid_rb = 4'd7; ifid_uses_rb = 1'b0;
    n_cmp++;
    if (dut_vec() !== {~INTERLOCK, 1'b1, INTERLOCK, 1'b1, 1'b1, 2'b01}) begin
      n_bad++;
      $display("FAIL hazard_ra: got %b, required %b", dut_vec(), {~INTERLOCK, 1'b1, INTERLOCK, 1'b1, 1'b1, 2'b01});
    end
    tick();
    n_cmp++;
    if (stall_cnt !== STALL_W'(INTERLOCK)) begin
      n_bad++;
      $display("FAIL hazard_stall_cnt: got %0d, required %0d", stall_cnt, INTERLOCK);
    end
    // After the bubble ID/EX holds a NOP: no hazard.
    idex_memread = 1'b0;
    n_cmp++;
    if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin
      n_bad++;
      $display("FAIL hazard_clears: got pc_en=%b bubble=%b, required 1/0", pc_en, idex_bubble);
    end
    tick();
    idex_memread = 1'b1; ifid_ra = 4'd5; ifid_rb = 4'd3; ifid_uses_rb = 1'b0;
    n_cmp++;
    if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin
      n_bad++;
      $display("FAIL rb_unused_no_stall: got pc_en=%b bubble=%b, required 1/0", pc_en, idex_bubble);
    end
    ifid_uses_rb = 1'b1;
    n_cmp++;
    if (pc_en !== ~INTERLOCK || idex_bubble !== INTERLOCK) begin
      n_bad++;
      $display("FAIL rb_used_stall: got pc_en=%b bubble=%b, required %b/%b", pc_en, idex_bubble, ~INTERLOCK, INTERLOCK);
    end
    tick();
    idex_wa = 4'd0; ifid_ra = 4'd0; ifid_uses_rb = 1'b0;
    n_cmp++;
    if (idex_bubble !== INTERLOCK) begin
      n_bad++;
      $display("FAIL r0_stall: got bubble=%b, required %b", idex_bubble, INTERLOCK);
    end
    tick();
    n_cmp++;
    if (stall_cnt !== STALL_W'(m_stall) || cycle_cnt !== CNT_W'(m_cyc)) begin
      n_bad++;
      $display("FAIL hazard_counters: got cyc=%0d stall=%0d, required %0d/%0d", cycle_cnt, stall_cnt, m_cyc, m_stall);
    end
    clear_hazard_inputs();
  endtask

  task automatic test_saturate();
    pause = 1'b0;
    clear_hazard_inputs();
    do_reset_release();
    tick();
    idex_memread = 1'b1; idex_wa = 4'd9; ifid_ra = 4'd9;
    repeat (300) tick();
    n_cmp++;
    if (cycle_cnt !== 16'd300) begin
      n_bad++;
      $display("FAIL sat_cycle_cnt: got %0d, required 300", cycle_cnt);
    end
    n_cmp++;
    if (stall_cnt !== (INTERLOCK ? 8'd255 : 8'd0)) begin
      n_bad++;
      $display("FAIL sat_stall_cnt: got %0d, required %0d", stall_cnt, INTERLOCK ? 255 : 0);
    end
    clear_hazard_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pause        = ($urandom_range(0, 3) == 0);
      step_pulse   = ($urandom_range(0, 4) == 0);
      idex_memread = $urandom_range(0, 1);
      idex_wa      = 4'($urandom_range(0, 3));
      ifid_ra      = 4'($urandom_range(0, 3));
      ifid_rb      = 4'($urandom_range(0, 3));
      ifid_uses_rb = $urandom_range(0, 1);
      n_cmp++;
      if (dut_vec() !== exp_vec() || cycle_cnt !== CNT_W'(m_cyc) || stall_cnt !== STALL_W'(m_stall)) begin
        n_bad++;
        $display("FAIL random_cycle %0d: got vec=%b cyc=%0d stall=%0d, required vec=%b cyc=%0d stall=%0d",
                 i, dut_vec(), cycle_cnt, stall_cnt, exp_vec(), m_cyc, m_stall);
      end
      tick();
    end
    step_pulse = 1'b0;
    clear_hazard_inputs();
  endtask

  task automatic test_async_reset();
    pause = 1'b1;
    tick();
    tick();
    step_pulse = 1'b1;
    idex_memread = 1'b1; idex_wa = 4'd4; ifid_ra = 4'd4;
    tick();
    step_pulse = 1'b0;
    n_cmp++;
    if (state !== 2'b10) begin
      n_bad++;
      $display("FAIL reach_step: got state=%b, required 10", state);
    end
    #2 RST = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({dut_vec(), cycle_cnt, stall_cnt} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got vec=%b cyc=%0d stall=%0d, required all 0", dut_vec(), cycle_cnt, stall_cnt);
    end
    @(negedge CLK);
    RST = 1'b0;
    clear_hazard_inputs();
    repeat (3) tick();
    n_cmp++;
    if (dut_vec() !== exp_vec() || state !== 2'b00) begin
      n_bad++;
      $display("FAIL no_pending_step: got %b, required %b", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_double_step();
    test_hazard();
    test_saturate();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
